// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the CORESPI FIFO slice: ceiling-log2
//                helper, legal parameter ranges and the bundled FIFO status
//                record.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Legal parameter ranges for the buffer
    localparam int c_DATA_WIDTH_MIN = 4;
    localparam int c_DATA_WIDTH_MAX = 32;
    localparam int c_FIFO_DEPTH_MIN = 2;
    localparam int c_FIFO_DEPTH_MAX = 256;

    // Smallest r such that 2**r >= value (0 for value <= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic udf;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/spi_fifo_ext_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_fifo_ext_if
//  Description : Control/data bundle of the extended FIFO. The slave modport
//                is the FIFO side; the master modport is the producer/consumer
//                and register side.
//                Inputs (to FIFO) : fiforst, data_in, flag_in, write_in,
//                                   read_in, afull_level, aempty_level,
//                                   sticky_clr
//                Outputs          : data_out, flag_out, full_out, empty_out,
//                                   afull_out, aempty_out, overflow_out,
//                                   underflow_out, ovf_sticky, udf_sticky,
//                                   fifo_count, peak_count
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_fifo_ext_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLAG_WIDTH = 1,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_WIDTH = clog2(FIFO_DEPTH + 1);

    logic                  fiforst;
    logic [DATA_WIDTH-1:0] data_in;
    logic [FLAG_WIDTH-1:0] flag_in;
    logic                  write_in;
    logic                  read_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [FLAG_WIDTH-1:0] flag_out;
    logic [CNT_WIDTH-1:0]  afull_level;
    logic [CNT_WIDTH-1:0]  aempty_level;
    logic                  full_out;
    logic                  empty_out;
    logic                  afull_out;
    logic                  aempty_out;
    logic                  overflow_out;
    logic                  underflow_out;
    logic                  ovf_sticky;
    logic                  udf_sticky;
    logic                  sticky_clr;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [CNT_WIDTH-1:0]  peak_count;

    modport slave (
        input  fiforst, data_in, flag_in, write_in, read_in,
               afull_level, aempty_level, sticky_clr,
        output data_out, flag_out, full_out, empty_out, afull_out, aempty_out,
               overflow_out, underflow_out, ovf_sticky, udf_sticky,
               fifo_count, peak_count
    );

    modport master (
        output fiforst, data_in, flag_in, write_in, read_in,
               afull_level, aempty_level, sticky_clr,
        input  data_out, flag_out, full_out, empty_out, afull_out, aempty_out,
               overflow_out, underflow_out, ovf_sticky, udf_sticky,
               fifo_count, peak_count
    );

endinterface
`default_nettype wire

// File: rtl/spi_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : spi_fifo_ram
//  Description : Unreset register array, one synchronous write port and one
//                asynchronous read port.
//                clk     : write clock
//                i_we    : write enable
//                i_waddr : write address,  i_wdata : write word
//                i_raddr : read address,   o_rdata : read word (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module spi_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic             clk,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_waddr,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic [AW-1:0]    i_raddr,
    output logic      [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/spi_fifo_ext.sv
`default_nettype none
// ============================================================================
//  Module      : spi_fifo_ext
//  Description : First-word-fall-through synchronous FIFO with per-entry tag,
//                live almost-full/almost-empty thresholds, overflow/underflow
//                pulses with sticky copies, and a high-water mark.
//                pclk   : clock (rising edge)
//                preset : synchronous active-high reset
//                bus    : spi_fifo_ext_if slave modport (all data/control)
//  Revision    : 1.0  initial release
// ============================================================================
module spi_fifo_ext
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLAG_WIDTH = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic      pclk,
    input  wire logic      preset,
    spi_fifo_ext_if.slave  bus
);

    localparam int CNT_WIDTH = clog2(FIFO_DEPTH + 1);
    // Pointers must address entries 0..FIFO_DEPTH-1, including non-power-of-two depths
    localparam int PTR_WIDTH = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH);
    localparam int ENT_WIDTH = DATA_WIDTH + FLAG_WIDTH;

    localparam logic [CNT_WIDTH-1:0] c_DEPTH   = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] c_PTR_TOP = PTR_WIDTH'(FIFO_DEPTH - 1);

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_peak;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_ovf_sticky;
    logic                 r_udf_sticky;

    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_wr_en;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic [ENT_WIDTH-1:0] w_rdata;
    fifo_status_t         w_status;

    // A write into a full FIFO is still accepted when a pop frees the slot
    assign w_wr_acc = bus.write_in & ((r_count < c_DEPTH) | (bus.read_in & ~r_empty));
    assign w_rd_acc = bus.read_in & ~r_empty;
    // Flush drops this cycle's write, so the array is left untouched
    assign w_wr_en  = w_wr_acc & ~bus.fiforst;

    assign w_count_next = bus.fiforst ? '0
                        : r_count + CNT_WIDTH'(w_wr_acc) - CNT_WIDTH'(w_rd_acc);

    spi_fifo_ram #(
        .WIDTH (ENT_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_WIDTH)
    ) u_ram (
        .clk     (pclk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.flag_in, bus.data_in}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_peak       <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else begin
            if (bus.fiforst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= (r_wr_ptr == c_PTR_TOP) ? '0 : r_wr_ptr + PTR_WIDTH'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= (r_rd_ptr == c_PTR_TOP) ? '0 : r_rd_ptr + PTR_WIDTH'(1);
                end
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            r_empty <= (w_count_next == '0);

            // A pulse in the same cycle as a clear wins
            r_ovf_sticky <= (r_ovf_sticky & ~bus.sticky_clr) | w_status.ovf;
            r_udf_sticky <= (r_udf_sticky & ~bus.sticky_clr) | w_status.udf;

            if (bus.sticky_clr) begin
                r_peak <= w_count_next;
            end else if (w_count_next > r_peak) begin
                r_peak <= w_count_next;
            end
        end
    end

    always_comb begin
        w_status        = '0;
        w_status.full   = r_full;
        w_status.empty  = r_empty;
        // Thresholds compare against live levels so a level change acts at once
        w_status.afull  = (r_count >= bus.afull_level);
        w_status.aempty = (r_count <= bus.aempty_level);
        w_status.ovf    = bus.write_in & ~w_wr_acc & ~bus.fiforst;
        w_status.udf    = bus.read_in & ~w_rd_acc & ~bus.fiforst;
    end

    assign bus.data_out      = w_rdata[DATA_WIDTH-1:0];
    assign bus.flag_out      = r_empty ? '0 : w_rdata[ENT_WIDTH-1:DATA_WIDTH];
    assign bus.full_out      = w_status.full;
    assign bus.empty_out     = w_status.empty;
    assign bus.afull_out     = w_status.afull;
    assign bus.aempty_out    = w_status.aempty;
    assign bus.overflow_out  = w_status.ovf;
    assign bus.underflow_out = w_status.udf;
    assign bus.ovf_sticky    = r_ovf_sticky;
    assign bus.udf_sticky    = r_udf_sticky;
    assign bus.fifo_count    = r_count;
    assign bus.peak_count    = r_peak;

endmodule
`default_nettype wire
